// File: rtl/lpc_coef_quantizer.sv
// Buffers one set of float LPC coefficients, picks a common shift from the largest exponent,
// and emits saturated, rounded fixed-point coefficients one per enabled cycle.
module lpc_coef_quantizer #(
    parameter int ORDER       = 12,
    parameter int PRECISION   = 15,
    parameter int MAX_SHIFT   = 15,
    parameter int SHIFT_WIDTH = 5,
    localparam int IDXW       = (ORDER > 1) ? $clog2(ORDER) : 1
) (
    input  logic                   iClock,
    input  logic                   iReset,
    input  logic                   iEnable,
    input  logic                   iValid,
    input  logic [31:0]            iCoef,
    output logic                   oReady,
    output logic                   oValid,
    output logic [PRECISION-1:0]   oCoef,
    output logic [IDXW-1:0]        oIndex,
    output logic [SHIFT_WIDTH-1:0] oShift,
    output logic                   oDone
);

    localparam int MW = PRECISION + 26;
    localparam logic [PRECISION-1:0] QMAX = {1'b0, {(PRECISION-1){1'b1}}};
    localparam logic [PRECISION-1:0] QMIN = {1'b1, {(PRECISION-1){1'b0}}};
    localparam logic [IDXW-1:0]      LAST = IDXW'(ORDER - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_EMIT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDXW-1:0]        cnt_q, cnt_d;
    logic [7:0]             maxe_q, maxe_d;
    logic [31:0]            buf_q [ORDER];
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic [PRECISION-1:0]   coef_q, coef_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;

    logic [7:0]             in_e8;
    logic [SHIFT_WIDTH-1:0] shift_calc;
    int                     s_raw;
    int                     s_clamped;

    logic [31:0]            cur;
    logic [7:0]             cur_e8;
    logic [23:0]            cur_m;
    int                     t;
    logic [MW-1:0]          mag;
    logic                   sat;
    logic                   big;
    logic [PRECISION-1:0]   qval;

    assign oReady = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign oValid = valid_q;
    assign oDone  = done_q;
    assign oCoef  = coef_q;
    assign oIndex = idx_q;
    assign oShift = shift_q;
    assign in_e8  = iCoef[30:23];

    // Exponent 0 never raises the running max, so an all-zero set leaves maxe_q at 0.
    always_comb begin
        s_raw     = PRECISION + 125 - int'(maxe_q);
        s_clamped = s_raw;
        if (maxe_q == 8'd0) begin
            s_clamped = 0;
        end else if (s_raw < 0) begin
            s_clamped = 0;
        end else if (s_raw > MAX_SHIFT) begin
            s_clamped = MAX_SHIFT;
        end
        shift_calc = SHIFT_WIDTH'(s_clamped);
    end

    always_comb begin
        cur    = buf_q[cnt_q];
        cur_e8 = cur[30:23];
        cur_m  = {1'b1, cur[22:0]};
        t      = int'(cur_e8) + int'(shift_q) - 150;
        mag    = '0;
        sat    = 1'b0;
        if (t >= 0) begin
            // Any left shift beyond PRECISION is already far past qmax.
            if (t > PRECISION) begin
                sat = 1'b1;
            end else begin
                mag = MW'(cur_m) << t;
            end
        end else if (t >= -25) begin
            mag = (MW'(cur_m) + (MW'(1) << (-t - 1))) >> (-t);
        end
        big  = sat || (mag > MW'(QMAX));
        qval = '0;
        if (cur_e8 == 8'hFF) begin
            qval = cur[31] ? QMIN : QMAX;
        end else if (cur_e8 != 8'd0) begin
            if (cur[31]) begin
                qval = big ? QMIN : -mag[PRECISION-1:0];
            end else begin
                qval = big ? QMAX : mag[PRECISION-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        maxe_d  = maxe_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        coef_d  = coef_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (iValid) begin
                    maxe_d = in_e8;
                    if (ORDER == 1) begin
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end else begin
                        cnt_d   = IDXW'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (iValid) begin
                    if (in_e8 > maxe_q) begin
                        maxe_d = in_e8;
                    end
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CALC: begin
                shift_d = shift_calc;
                cnt_d   = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                valid_d = 1'b1;
                coef_d  = qval;
                idx_d   = cnt_q;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            maxe_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            coef_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            for (int i = 0; i < ORDER; i++) begin
                buf_q[i] <= '0;
            end
        end else if (iEnable) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            maxe_q  <= maxe_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            coef_q  <= coef_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            if (oReady && iValid) begin
                buf_q[cnt_q] <= iCoef;
            end
        end
    end

endmodule

// File: tb/tb_lpc_coef_quantizer.sv
// Directed bench for lpc_coef_quantizer (ORDER=4): scoreboard of expected coefficients,
// checked at the falling edge whenever the DUT advanced with oValid high.
module tb_lpc_coef_quantizer;

    logic        clk = 1'b0;
    logic        iReset, iEnable, iValid;
    logic [31:0] iCoef;
    logic        oReady, oValid, oDone;
    logic [14:0] oCoef;
    logic [1:0]  oIndex;
    logic [4:0]  oShift;

    typedef struct {
        int idx;
        int val;
    } exp_t;

    exp_t sb[$];
    int   exp_shift = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   done_cnt  = 0;
    logic en_q      = 1'b0;

    lpc_coef_quantizer #(
        .ORDER(4), .PRECISION(15), .MAX_SHIFT(15), .SHIFT_WIDTH(5)
    ) dut (
        .iClock(clk), .iReset(iReset), .iEnable(iEnable), .iValid(iValid), .iCoef(iCoef),
        .oReady(oReady), .oValid(oValid), .oCoef(oCoef), .oIndex(oIndex),
        .oShift(oShift), .oDone(oDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) en_q <= iEnable;

    // Outputs only change on enabled edges, so a frozen cycle is not a new sample.
    always @(negedge clk) begin
        if (en_q && oValid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL unexpected_output: observed idx %0d coef %0d, expected no output", oIndex, $signed(oCoef));
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                assert (int'(oIndex) === e.idx) else begin
                    errors++;
                    $error("FAIL index: observed %0d expected %0d", oIndex, e.idx);
                end
                checks++;
                assert (int'($signed(oCoef)) === e.val) else begin
                    errors++;
                    $error("FAIL coef[%0d]: observed %0d expected %0d", e.idx, $signed(oCoef), e.val);
                end
                checks++;
                assert (int'(oShift) === exp_shift) else begin
                    errors++;
                    $error("FAIL shift_during_emit: observed %0d expected %0d", oShift, exp_shift);
                end
            end
        end
        if (en_q && oDone) begin
            done_cnt++;
            checks++;
            assert (sb.size() == 0) else begin
                errors++;
                $error("FAIL done_early: observed %0d pending, expected 0", sb.size());
            end
            checks++;
            assert (oValid === 1'b0) else begin
                errors++;
                $error("FAIL valid_with_done: observed %b expected 0", oValid);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_set(input int sh, input int v0, input int v1, input int v2, input int v3);
        exp_t e;
        exp_shift = sh;
        e.idx = 0; e.val = v0; sb.push_back(e);
        e.idx = 1; e.val = v1; sb.push_back(e);
        e.idx = 2; e.val = v2; sb.push_back(e);
        e.idx = 3; e.val = v3; sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] c, input bit gap);
        iValid = 1'b1;
        iCoef  = c;
        for (int k = 0; k < 100 && !oReady; k++) tick();
        checks++;
        assert (oReady === 1'b1) else begin
            errors++;
            $error("FAIL ready_timeout: observed %b expected 1", oReady);
        end
        tick();
        iValid = 1'b0;
        iCoef  = 32'hDEAD_BEEF;
        if (gap) begin
            tick();
            tick();
        end
    endtask

    task automatic wait_done(input int start);
        for (int k = 0; k < 60 && done_cnt == start; k++) tick();
        checks++;
        assert (done_cnt != start) else begin
            errors++;
            $error("FAIL done_timeout: observed %0d dones expected %0d", done_cnt, start + 1);
        end
        tick();
    endtask

    task automatic run_set(input logic [31:0] c0, input logic [31:0] c1,
                           input logic [31:0] c2, input logic [31:0] c3,
                           input int sh, input int v0, input int v1, input int v2, input int v3);
        int start;
        start = done_cnt;
        push_set(sh, v0, v1, v2, v3);
        send(c0, 1'b0);
        send(c1, 1'b0);
        send(c2, 1'b0);
        send(c3, 1'b0);
        wait_done(start);
    endtask

    initial begin
        int start;
        iReset  = 1'b0;
        iEnable = 1'b1;
        iValid  = 1'b0;
        iCoef   = '0;
        repeat (3) tick();

        checks++; assert (oValid === 1'b0) else begin errors++; $error("FAIL reset_valid: observed %b expected 0", oValid); end
        checks++; assert (oDone === 1'b0) else begin errors++; $error("FAIL reset_done: observed %b expected 0", oDone); end
        checks++; assert (oCoef === 15'd0) else begin errors++; $error("FAIL reset_coef: observed %0d expected 0", oCoef); end
        checks++; assert (oIndex === 2'd0) else begin errors++; $error("FAIL reset_index: observed %0d expected 0", oIndex); end
        checks++; assert (oShift === 5'd0) else begin errors++; $error("FAIL reset_shift: observed %0d expected 0", oShift); end
        checks++; assert (oReady === 1'b1) else begin errors++; $error("FAIL reset_ready: observed %b expected 1", oReady); end

        iReset = 1'b1;
        tick();

        run_set(32'h3FC00000, 32'hBF400000, 32'h3E800000, 32'h00000000, 13, 12288, -6144, 2048, 0);
        run_set(32'h3FFFFFFF, 32'hBFFFFFFF, 32'h3F800000, 32'h3F000000, 13, 16383, -16384, 8192, 4096);
        run_set(32'h47800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 16383, 1, 1, 1);
        run_set(32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 0, 0, 0);
        run_set(32'h35800000, 32'h3E000000, 32'h3E000000, 32'h3E000000, 15, 0, 4096, 4096, 4096);
        run_set(32'h7F800000, 32'hFF800000, 32'h3F800000, 32'hBF800000, 0, 16383, -16384, 1, -1);
        run_set(32'h3E000000, 32'h3E000000, 32'h3E000000, 32'h3E000000, 15, 4096, 4096, 4096, 4096);

        // Gaps while loading, iValid held during CALC/EMIT, enable dropped after the first output.
        start = done_cnt;
        push_set(13, 12288, -6144, 2048, 0);
        send(32'h3FC00000, 1'b1);
        send(32'hBF400000, 1'b1);
        send(32'h3E800000, 1'b1);
        send(32'h00000000, 1'b0);
        iValid = 1'b1;
        iCoef  = 32'h7F800000;
        tick();
        tick();
        iValid  = 1'b0;
        iEnable = 1'b0;
        repeat (3) begin
            tick();
            checks++; assert (oValid === 1'b1) else begin errors++; $error("FAIL stall_valid: observed %b expected 1", oValid); end
            checks++; assert (oIndex === 2'd0) else begin errors++; $error("FAIL stall_index: observed %0d expected 0", oIndex); end
            checks++; assert (int'($signed(oCoef)) === 12288) else begin errors++; $error("FAIL stall_coef: observed %0d expected 12288", $signed(oCoef)); end
            checks++; assert (oReady === 1'b0) else begin errors++; $error("FAIL stall_ready: observed %b expected 0", oReady); end
        end
        iEnable = 1'b1;
        wait_done(start);

        // Last set left shift 13; a reset part-way through loading must discard and clear.
        send(32'h47800000, 1'b0);
        send(32'h47800000, 1'b0);
        iReset = 1'b0;
        tick();
        checks++; assert (oShift === 5'd0) else begin errors++; $error("FAIL midreset_shift: observed %0d expected 0", oShift); end
        checks++; assert (oReady === 1'b1) else begin errors++; $error("FAIL midreset_ready: observed %b expected 1", oReady); end
        checks++; assert (oValid === 1'b0) else begin errors++; $error("FAIL midreset_valid: observed %b expected 0", oValid); end
        iReset = 1'b1;
        repeat (8) tick();
        run_set(32'h3FC00000, 32'hBF400000, 32'h3E800000, 32'h00000000, 13, 12288, -6144, 2048, 0);

        repeat (5) tick();
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL leftover: observed %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpc_coef_quantizer.md
Name: lpc_coef_quantizer

Overview:
- Downstream neighbour of the Levinson-Durbin stage: accepts its IEEE-754 single-precision LPC coefficients serially, one per cycle.
- Picks one common quantization shift for the whole set, then emits signed fixed-point coefficients plus the shift for the residual/encoder stage.
- Buffers one full coefficient set. Fixed-point only; no float adders.

Parameters:
- ORDER, 12, number of coefficients per set (>=1).
- PRECISION, 15, quantized coefficient width in bits including sign; qmax = 2^(PRECISION-1)-1, qmin = -2^(PRECISION-1).
- MAX_SHIFT, 15, upper clamp for the shift.
- SHIFT_WIDTH, 5, width of oShift.

Ports:
- iClock  in  1  clock, rising edge.
- iReset  in  1  synchronous, active-low reset.
- iEnable  in  1  clock enable; when low all state and outputs hold.
- iValid  in  1  iCoef valid this cycle.
- iCoef  in  32  IEEE-754 single coefficient.
- oReady  out  1  high in IDLE/LOAD; block accepts iValid.
- oValid  out  1  oCoef/oIndex valid.
- oCoef  out  PRECISION  quantized coefficient, two's complement.
- oIndex  out  clog2(ORDER)  coefficient index of oCoef.
- oShift  out  SHIFT_WIDTH  chosen shift; stable from first oValid until next set's CALC.
- oDone  out  1  one-cycle pulse after the last coefficient of a set.

Behaviour:
- Reset (iReset==0 at edge): state=IDLE, buffer/max-exponent/counters cleared, oValid=0, oDone=0, oCoef=0, oIndex=0, oShift=0, oReady=1. Reset mid-set discards the set.
- All transitions below require iEnable=1; iEnable=0 freezes the FSM, counters and outputs.
- IDLE: iValid -> store coef[0], count=1, go LOAD (or CALC if ORDER==1).
- LOAD: each iValid stores coef[count]; count increments; the cycle storing coef[ORDER-1] goes to CALC. Gaps in iValid are allowed.
- Max exponent: track the max biased exponent e8 over stored coefs. Exponent-0 inputs (zero/denormal) count as zero.
- CALC (1 cycle, oReady=0, iValid ignored): E = maxe8-127; s = PRECISION-2-E, clamped to [0,MAX_SHIFT]; oShift<=s. If all coefs are zero, s=0.
- EMIT (ORDER cycles, oReady=0, iValid ignored): per coef, M={1,mant[22:0]}, t = e8-150+s.
- If t>=0: mag = M<<t, computed saturating.
- If t<0: mag = (M + 2^(-t-1)) >> -t, i.e. round half away from zero; if -t>25, mag=0.
- Apply sign, clamp to [qmin,qmax]. Exponent 0 gives 0. Exponent 255 (Inf/NaN) saturates to qmax, or qmin when the sign bit is set.
- Output: oValid=1, oIndex=i for i=0..ORDER-1 on consecutive enabled cycles.
- DONE: 1 cycle, oDone=1, oValid=0, then IDLE with oReady=1.
- Latency: last coef accepted at edge N; oShift valid after N+1; oCoef[0] with oValid after edge N+2; oDone after edge N+ORDER+2.
- Back-to-back: the next set's first iValid is accepted no earlier than the IDLE cycle after oDone.

Test Plan:
- ORDER=4, PRECISION=15, coefs 0x3FC00000(1.5), 0xBF400000(-0.75), 0x3E800000(0.25), 0x00000000 -> oShift=13; oCoef 12288, -6144, 2048, 0 at oIndex 0..3; oDone one cycle after the last.
- Rounding/clamp: coefs 0x3FFFFFFF(~1.99999988), 0xBFFFFFFF, 0x3F800000, 0x3F000000 -> shift 13; 16383 (clamped), -16384, 8192, 4096.
- Shift clamps: all coefs 0x3E000000(0.125) -> raw s=16 clamps to 15, each 4096. Coef 0x47800000(65536.0) with others 1.0 -> raw s=-3 clamps to 0; outputs 16383, 1, 1, 1.
- All-zero set -> oShift=0, four zeros, oDone. Tiny coef 0x35800000 alongside 0x3E000000 -> 0 (rounds down).
- Stall/gaps: iValid gaps during LOAD and iEnable low for 3 cycles mid-EMIT -> identical outputs, oIndex contiguous, outputs held while stalled; iValid during EMIT ignored.
- Reset mid-LOAD after 2 coefs, then a full new set -> only the new set is emitted, with values matching the first scenario.
